pulse_stretcher: RTL

Converts single-cycle pulses back into a level: each accepted pulse on `P` drives `L` high for a programmable number of clock cycles, followed by an enforced minimum low gap. It is the inverse of the team's level-to-pulse edge detector. It regenerates strobes and enables of defined width from detector output or from other one-cycle event sources. Optional retriggering extends the level instead of dropping the pulse.

---
 rtl/pulse_stretcher_if.sv | 21 ++
 rtl/pulse_stretcher.sv | 101 ++++++++++
 2 files changed

// File: rtl/pulse_stretcher_if.sv
// rtl/pulse_stretcher_if.sv - pulse request and stretched level signal bundle
interface pulse_stretcher_if #(
    parameter int WIDTH = 8
);
    logic             P;
    logic [WIDTH-1:0] len;
    logic             retrig;
    logic             L;
    logic             busy;
    logic             drop;

    modport master (
        output P, len, retrig,
        input  L, busy, drop
    );

    modport slave (
        input  P, len, retrig,
        output L, busy, drop
    );
endinterface

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretches one-cycle pulses into levels of programmable width
module pulse_stretcher #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic              clk,
    input  logic              reset,
    pulse_stretcher_if.slave  ps
);
    // Gap counter holds GAP-1 down to 0; keep at least one bit so GAP=0 still elaborates.
    localparam int GW = ($clog2(GAP + 1) < 1) ? 1 : $clog2(GAP + 1);
    localparam logic [GW-1:0]    GAP_LOAD = GW'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [GW-1:0]    GAP_ONE  = GW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAPS = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] cnt, cnt_nx;
    logic [GW-1:0]    gcnt, gcnt_nx;
    logic             l_q, busy_q, drop_q;
    logic             drop_nx;
    logic             len_ok;

    assign len_ok = (ps.len != '0);

    // State, counters and registered outputs; reset abandons any level in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            gcnt   <= '0;
            l_q    <= 1'b0;
            busy_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            gcnt   <= gcnt_nx;
            l_q    <= (state_nx == HIGH);
            busy_q <= (state_nx != IDLE);
            drop_q <= drop_nx;
        end
    end

    // Next-state: accept in IDLE, reload or count down in HIGH, enforce the low gap in GAPS.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        gcnt_nx  = gcnt;
        drop_nx  = 1'b0;
        case (state)
            IDLE: begin
                // A zero-length request is silently ignored, not counted as a drop.
                if (ps.P && len_ok) begin
                    state_nx = HIGH;
                    cnt_nx   = ps.len - CNT_ONE;
                end
            end
            HIGH: begin
                // A reload wins over expiry so back-to-back segments never glitch low.
                if (ps.P && ps.retrig && len_ok) begin
                    cnt_nx = ps.len - CNT_ONE;
                end else begin
                    if (ps.P) begin
                        drop_nx = 1'b1;
                    end
                    if (cnt != '0) begin
                        cnt_nx = cnt - CNT_ONE;
                    end else if (GAP > 0) begin
                        state_nx = GAPS;
                        gcnt_nx  = GAP_LOAD;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            GAPS: begin
                if (ps.P) begin
                    drop_nx = 1'b1;
                end
                if (gcnt == '0) begin
                    state_nx = IDLE;
                end else begin
                    gcnt_nx = gcnt - GAP_ONE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign ps.L    = l_q;
    assign ps.busy = busy_q;
    assign ps.drop = drop_q;
endmodule
